digit_unloader: RTL and testbench

//  Consumer side of the keypad digit-entry shift register. On a start pulse it

---
 rtl/digit_unloader.sv | 125 ++++++++++++
 tb/tb_digit_unloader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/digit_unloader.sv
// Snapshots the keypad entry register on start and streams its digits out
// oldest-first over valid/ready, accumulating their decimal value.
module digit_unloader #(
  parameter int NDIG = 6,
  parameter int DW   = 8,
  parameter int VW   = 20
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    cnt,
  input  logic [DW-1:0] din0,
  input  logic [DW-1:0] din1,
  input  logic [DW-1:0] din2,
  input  logic [DW-1:0] din3,
  input  logic [DW-1:0] din4,
  input  logic [DW-1:0] din5,
  output logic [DW-1:0] digit,
  output logic          digit_valid,
  input  logic          digit_ready,
  output logic [VW-1:0] value,
  output logic          busy,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE} state_t;

  state_t        r_state;
  logic [DW-1:0] r_snap [NDIG];
  logic [2:0]    r_idx;
  logic [DW-1:0] r_digit;
  logic          r_valid;
  logic [VW-1:0] r_value;
  logic          r_busy;
  logic          r_done;
  logic          r_err;

  logic [DW-1:0] w_din [NDIG];
  logic [2:0]    w_first;
  logic          w_xfer;
  logic          w_legal;
  logic [VW-1:0] w_acc;

  assign w_din[0] = din0;
  assign w_din[1] = din1;
  assign w_din[2] = din2;
  assign w_din[3] = din3;
  assign w_din[4] = din4;
  assign w_din[5] = din5;

  // Oldest valid digit sits at slot cnt-1; only used when 1 <= cnt <= NDIG.
  assign w_first = cnt[2:0] - 3'd1;
  assign w_xfer  = r_valid & digit_ready;
  assign w_legal = (r_digit < DW'(10));
  assign w_acc   = r_value * VW'(10) + VW'(r_digit);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_digit <= '0;
      r_valid <= 1'b0;
      r_value <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            for (int i = 0; i < NDIG; i++) r_snap[i] <= w_din[i];
            r_value <= '0;
            r_err   <= 1'b0;
            if (cnt == 4'd0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else if (cnt > 4'(NDIG)) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_idx   <= w_first;
              r_digit <= w_din[w_first];
              r_valid <= 1'b1;
              r_busy  <= 1'b1;
              r_state <= S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (w_xfer) begin
            if (w_legal && (r_idx != 3'd0)) begin
              r_value <= w_acc;
              r_idx   <= r_idx - 3'd1;
              r_digit <= r_snap[r_idx - 3'd1];
            end else begin
              // Last digit or an illegal code: either way the unload ends here.
              if (w_legal) r_value <= w_acc;
              else         r_err   <= 1'b1;
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign digit       = r_digit;
  assign digit_valid = r_valid;
  assign value       = r_value;
  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;

endmodule

// File: tb/tb_digit_unloader.sv
// Bench for digit_unloader: directed vector table, reset/abort sequence and
// randomized unloads checked against a digit-list reference model.
module tb_digit_unloader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, start, digit_ready;
  logic [3:0]      cnt;
  logic [5:0][7:0] din_v;
  logic [7:0]      digit;
  logic            digit_valid, busy, done, err;
  logic [19:0]     value;

  digit_unloader dut (
    .clk(clk), .rst(rst), .start(start), .cnt(cnt),
    .din0(din_v[0]), .din1(din_v[1]), .din2(din_v[2]),
    .din3(din_v[3]), .din4(din_v[4]), .din5(din_v[5]),
    .digit(digit), .digit_valid(digit_valid), .digit_ready(digit_ready),
    .value(value), .busy(busy), .done(done), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Reference: walk slots cnt-1 down to 0, stop after the first non-digit.
  task automatic model(input int c, input logic [5:0][7:0] d,
                       output int md[6], output int mn, output int mv, output int me);
    mn = 0; mv = 0; me = 0;
    for (int k = 0; k < 6; k++) md[k] = 0;
    if (c == 0) return;
    if (c > 6) begin me = 1; return; end
    for (int k = c - 1; k >= 0; k--) begin
      md[mn] = int'(d[k]);
      mn++;
      if (d[k] > 9) begin me = 1; return; end
      mv = (mv * 10 + int'(d[k])) % (1 << 20);
    end
  endtask

  // mode 0: ready always 1; mode 1: random ready, din/cnt churn, stray starts;
  // mode 2: ready held low for cycles 1..4.
  task automatic run_unload(input string tag, input int c, input logic [5:0][7:0] d,
                            input int mode, input int exp_lat, input int ev, input int ee);
    int md[6]; int mn, mv, me;
    int ngot, lat;
    bit seen_done, stall, r;
    logic [7:0] pd;
    model(c, d, md, mn, mv, me);
    ngot = 0; lat = 0; seen_done = 0; stall = 0; pd = 0;
    @(negedge clk);
    cnt = 4'(c); din_v = d; start = 1'b1; digit_ready = 1'b0;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (done) begin lat = cyc; seen_done = 1; break; end
      chk({tag, " busy"}, busy, 1);
      if (stall) begin
        chk({tag, " hold_valid"}, digit_valid, 1);
        chk({tag, " hold_digit"}, digit, pd);
      end
      case (mode)
        0:       r = 1'b1;
        2:       r = (cyc > 4);
        default: r = ($urandom_range(0, 9) < 6);
      endcase
      digit_ready = r;
      if (digit_valid && r) begin
        if (ngot < 6) chk({tag, " digit"}, digit, md[ngot]);
        ngot++;
        stall = 0;
      end else begin
        stall = digit_valid;
        pd = digit;
      end
      if (mode == 1) begin
        cnt = 4'($urandom_range(1, 6));
        for (int k = 0; k < 6; k++) din_v[k] = 8'($urandom_range(0, 9));
        start = ($urandom_range(0, 4) == 0);
      end else begin
        start = 1'b0;
      end
    end
    if (!seen_done) chk({tag, " done_timeout"}, 0, 1);
    chk({tag, " ndig"}, ngot, mn);
    chk({tag, " value"}, value, ev);
    chk({tag, " err"}, err, ee);
    chk({tag, " busy_at_done"}, busy, 0);
    chk({tag, " valid_at_done"}, digit_valid, 0);
    if (exp_lat > 0) chk({tag, " done_latency"}, lat, exp_lat);
    start = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " idle_not_busy"}, busy, 0);
    chk({tag, " value_hold"}, value, ev);
    chk({tag, " err_hold"}, err, ee);
    $display("unload %s cnt=%0d digits=%0d value=%0d err=%0d lat=%0d", tag, c, ngot, value, err, lat);
  endtask

  typedef struct {
    string           tag;
    int              c;
    logic [5:0][7:0] d;
    int              mode;
    int              lat;
    int              ev;
    int              ee;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int mdd[6]; int mn, mv, me, c;
    logic [5:0][7:0] d;

    tbl[0] = '{"t1_basic",   3,  {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3},    0, 4, 123,    0};
    tbl[1] = '{"t2_stall",   3,  {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3},    2, 8, 123,    0};
    tbl[2] = '{"t3_full",    6,  {8'd9, 8'd9, 8'd9, 8'd9, 8'd9, 8'd9},    0, 7, 999999, 0};
    tbl[3] = '{"cnt0",       0,  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},    0, 1, 0,      0};
    tbl[4] = '{"t4_bad",     2,  {8'd0, 8'd0, 8'd0, 8'd0, 8'h0A, 8'd5},   0, 2, 0,      1};
    tbl[5] = '{"cnt7",       7,  {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6},    0, 1, 0,      1};
    tbl[6] = '{"one",        1,  {8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd7},    0, 2, 7,      0};
    tbl[7] = '{"cnt15",      15, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1},    0, 1, 0,      1};
    tbl[8] = '{"lead_zero",  4,  {8'd7, 8'd7, 8'd0, 8'd0, 8'd0, 8'd5},    0, 5, 5,      0};
    tbl[9] = '{"bad_mid",    3,  {8'd0, 8'd0, 8'd0, 8'd4, 8'hFF, 8'd1},   0, 3, 4,      1};

    rst = 1'b1; start = 1'b0; digit_ready = 1'b0; cnt = '0; din_v = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset digit", digit, 0);
    chk("reset valid", digit_valid, 0);
    chk("reset value", value, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);

    for (int i = 0; i < 10; i++)
      run_unload(tbl[i].tag, tbl[i].c, tbl[i].d, tbl[i].mode, tbl[i].lat, tbl[i].ev, tbl[i].ee);

    // Reset in the middle of an unload: one digit already taken.
    @(negedge clk);
    cnt = 4'd3; din_v = {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3}; start = 1'b1; digit_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("t5 first_digit", digit, 1);
    chk("t5 first_valid", digit_valid, 1);
    @(negedge clk);
    chk("t5 second_digit", digit, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5 rst digit", digit, 0);
    chk("t5 rst valid", digit_valid, 0);
    chk("t5 rst value", value, 0);
    chk("t5 rst busy", busy, 0);
    chk("t5 rst done", done, 0);
    chk("t5 rst err", err, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5 no_done", done, 0);
      chk("t5 no_valid", digit_valid, 0);
    end
    $display("reset abort sequence checked");
    run_unload("t5_after", 3, {8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3}, 0, 4, 123, 0);

    for (int n = 0; n < 40; n++) begin
      c = $urandom_range(0, 8);
      for (int k = 0; k < 6; k++)
        d[k] = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(10, 255)) : 8'($urandom_range(0, 9));
      model(c, d, mdd, mn, mv, me);
      run_unload("rand", c, d, 1, -1, mv, me);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
